// File: rtl/pulse_sync_mc.sv
// pulse_sync_mc: per-channel strobe synchronizer with rising-edge data capture and valid/ack handshake.
// Define PULSE_SYNC_MC_OVERRUN_EN to build the sticky overrun flags and the dropped-strobe counter.
module pulse_sync_mc #(
    parameter int unsigned N      = 8,
    parameter int unsigned CH     = 2,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [CH-1:0]   stb,
    input  logic [CH*N-1:0] data_in,
    output logic [CH*N-1:0] data_out,
    output logic [CH-1:0]   valid,
    input  logic [CH-1:0]   ack,
    output logic [CH-1:0]   overrun,
    output logic [7:0]      ovr_cnt
);
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    logic [STAGES-1:0] sync_q  [CH];
    logic [STAGES-1:0] sync_d  [CH];
    state_e            state_q [CH];
    state_e            state_d [CH];
    logic [CH-1:0]     sd_q;
    logic [CH-1:0]     sd_d;
    logic [CH-1:0]     rise;
    logic [CH*N-1:0]   data_q;
    logic [CH*N-1:0]   data_d;

    // Synchronizer shift, edge detect and per-channel IDLE/FULL handshake.
    always_comb begin
        sd_d   = sd_q;
        rise   = '0;
        data_d = data_q;
        for (int unsigned c = 0; c < CH; c++) begin
            sync_d[c]  = {sync_q[c][STAGES-2:0], stb[c]};
            sd_d[c]    = sync_q[c][STAGES-1];
            rise[c]    = sync_q[c][STAGES-1] & ~sd_q[c];
            state_d[c] = state_q[c];
            case (state_q[c])
                IDLE: begin
                    if (rise[c]) begin
                        state_d[c]        = FULL;
                        data_d[c*N +: N]  = data_in[c*N +: N];
                    end
                end
                FULL: begin
                    // Rise with ack replaces the word back-to-back; rise alone is dropped.
                    if (rise[c] && ack[c]) begin
                        data_d[c*N +: N] = data_in[c*N +: N];
                    end else if (!rise[c] && ack[c]) begin
                        state_d[c] = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < CH; c++) begin
                sync_q[c]  <= '0;
                state_q[c] <= IDLE;
            end
            sd_q   <= '0;
            data_q <= '0;
        end else if (ena) begin
            for (int unsigned c = 0; c < CH; c++) begin
                sync_q[c]  <= sync_d[c];
                state_q[c] <= state_d[c];
            end
            sd_q   <= sd_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        valid = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            valid[c] = (state_q[c] == FULL);
        end
    end

    assign data_out = data_q;

`ifdef PULSE_SYNC_MC_OVERRUN_EN
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic [CH-1:0]    ovr_q;
    logic [CH-1:0]    ovr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    int unsigned      drops;
    int unsigned      cnt_sum;

    // Count every channel dropping a rise this cycle; saturate rather than wrap.
    always_comb begin
        ovr_d = ovr_q;
        drops = 0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (rise[c] && (state_q[c] == FULL) && !ack[c]) begin
                ovr_d[c] = 1'b1;
                drops    = drops + 1;
            end
        end
        cnt_sum = 32'(cnt_q) + drops;
        cnt_d   = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= '0;
            cnt_q <= '0;
        end else if (ena) begin
            ovr_q <= ovr_d;
            cnt_q <= cnt_d;
        end
    end

    assign overrun = ovr_q;
    assign ovr_cnt = cnt_q;
`else
    assign overrun = '0;
    assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_sync_mc.sv
// tb_pulse_sync_mc: scoreboard bench for pulse_sync_mc at default parameters.
// Overrun expectations follow PULSE_SYNC_MC_OVERRUN_EN (flags and counter read 0 when undefined).
module tb_pulse_sync_mc;
    localparam int unsigned N      = 8;
    localparam int unsigned CH     = 2;
    localparam int unsigned STAGES = 2;
    localparam int unsigned LAT    = STAGES + 1;
`ifdef PULSE_SYNC_MC_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic [CH-1:0]   stb;
    logic [CH-1:0]   ack;
    logic [CH*N-1:0] data_in;
    logic [CH*N-1:0] data_out;
    logic [CH-1:0]   valid;
    logic [CH-1:0]   overrun;
    logic [7:0]      ovr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]    exp0 [$];
    logic [7:0]    exp1 [$];
    logic [CH-1:0] pv = '0;
    logic [7:0]    pd [CH];

    pulse_sync_mc #(.N(N), .CH(CH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .stb      (stb),
        .data_in  (data_in),
        .data_out (data_out),
        .valid    (valid),
        .ack      (ack),
        .overrun  (overrun),
        .ovr_cnt  (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Capture monitor: a new word is valid rising or the held word changing while valid.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (valid[c] && (!pv[c] || data_out[c*N +: N] != pd[c])) begin
                if (c == 0) begin
                    check("ch0 capture pending", 32'(exp0.size() != 0), 32'd1);
                    if (exp0.size() != 0) check("ch0 capture data", 32'(data_out[7:0]), 32'(exp0.pop_front()));
                end else begin
                    check("ch1 capture pending", 32'(exp1.size() != 0), 32'd1);
                    if (exp1.size() != 0) check("ch1 capture data", 32'(data_out[15:8]), 32'(exp1.pop_front()));
                end
            end
            pv[c] = valid[c];
            pd[c] = data_out[c*N +: N];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; stb = '0; ack = '0; data_in = '0;
        wait_neg(2);
        check("reset valid",    32'(valid),    32'h0);
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset overrun",  32'(overrun),  32'h0);
        check("reset ovr_cnt",  32'(ovr_cnt),  32'h0);
        rst = 1'b0;
        wait_neg(1);

        // Basic capture latency and ack.
        data_in[7:0] = 8'hA5; stb[0] = 1'b1; exp0.push_back(8'hA5);
        wait_neg(LAT - 1);
        check("t1 valid before latency", 32'(valid[0]), 32'h0);
        wait_neg(1);
        check("t1 valid", 32'(valid[0]), 32'h1);
        check("t1 data",  32'(data_out[7:0]), 32'hA5);
        wait_neg(2);
        ack[0] = 1'b1;
        wait_neg(1);
        ack[0] = 1'b0;
        check("t1 valid after ack", 32'(valid[0]), 32'h0);
        stb[0] = 1'b0;
        wait_neg(4);

        // Held-high strobe gives exactly one capture; re-arm needs a low phase.
        data_in[7:0] = 8'h3C; stb[0] = 1'b1; exp0.push_back(8'h3C);
        wait_neg(20);
        check("t2 valid held", 32'(valid[0]), 32'h1);
        check("t2 data held",  32'(data_out[7:0]), 32'h3C);
        ack[0] = 1'b1;
        wait_neg(1);
        ack[0] = 1'b0;
        wait_neg(6);
        check("t2 no recapture on held stb", 32'(valid[0]), 32'h0);
        stb[0] = 1'b0;
        wait_neg(4);
        data_in[7:0] = 8'h5A; stb[0] = 1'b1; exp0.push_back(8'h5A);
        wait_neg(LAT);
        check("t2 second capture valid", 32'(valid[0]), 32'h1);
        check("t2 second capture data",  32'(data_out[7:0]), 32'h5A);
        stb[0] = 1'b0; ack[0] = 1'b1;
        wait_neg(1);
        ack[0] = 1'b0;
        wait_neg(3);

        // Overrun: drop while FULL, then saturate the counter.
        data_in[7:0] = 8'h11; stb[0] = 1'b1; exp0.push_back(8'h11);
        wait_neg(4);
        stb[0] = 1'b0;
        wait_neg(4);
        data_in[7:0] = 8'h22; stb[0] = 1'b1;
        wait_neg(4);
        stb[0] = 1'b0;
        check("t3 data kept",  32'(data_out[7:0]), 32'h11);
        check("t3 valid kept", 32'(valid[0]), 32'h1);
        check("t3 overrun set", 32'(overrun[0]), 32'(OVR));
        check("t3 ovr_cnt one", 32'(ovr_cnt), OVR ? 32'd1 : 32'd0);
        wait_neg(4);
        repeat (299) begin
            stb[0] = 1'b1;
            wait_neg(4);
            stb[0] = 1'b0;
            wait_neg(4);
        end
        check("t3 ovr_cnt saturated", 32'(ovr_cnt), OVR ? 32'd255 : 32'd0);
        check("t3 data after drops",  32'(data_out[7:0]), 32'h11);
        check("t3 ch1 overrun clear", 32'(overrun[1]), 32'h0);
        ack[0] = 1'b1;
        wait_neg(1);
        ack[0] = 1'b0;
        wait_neg(3);

        // Channel 1: rise and ack in the same cycle replace the word with no bubble.
        data_in[15:8] = 8'h44; stb[1] = 1'b1; exp1.push_back(8'h44);
        wait_neg(4);
        check("t4 ch1 first valid", 32'(valid[1]), 32'h1);
        stb[1] = 1'b0;
        wait_neg(4);
        data_in[15:8] = 8'h77; stb[1] = 1'b1; exp1.push_back(8'h77);
        wait_neg(LAT - 1);
        check("t4 valid before swap", 32'(valid[1]), 32'h1);
        ack[1] = 1'b1;
        wait_neg(1);
        ack[1] = 1'b0;
        check("t4 no bubble",    32'(valid[1]), 32'h1);
        check("t4 swapped data", 32'(data_out[15:8]), 32'h77);
        check("t4 no drop counted", 32'(ovr_cnt), OVR ? 32'd255 : 32'd0);
        wait_neg(1);
        check("t4 still valid", 32'(valid[1]), 32'h1);
        stb[1] = 1'b0; ack[1] = 1'b1;
        wait_neg(1);
        ack[1] = 1'b0;
        check("t4 ch1 consumed", 32'(valid[1]), 32'h0);
        wait_neg(4);

        // Enable stall after edge 2 of a capture.
        data_in[7:0] = 8'h99; stb[0] = 1'b1; exp0.push_back(8'h99);
        wait_neg(2);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_neg(1);
            check("t5 stalled valid", 32'(valid[0]), 32'h0);
            check("t5 stalled data",  32'(data_out[7:0]), 32'h11);
        end
        ena = 1'b1;
        wait_neg(1);
        check("t5 resumed valid", 32'(valid[0]), 32'h1);
        check("t5 resumed data",  32'(data_out[7:0]), 32'h99);

        // Asynchronous reset mid-handshake, strobe still high afterwards.
        check("t6 pre overrun", 32'(overrun[0]), 32'(OVR));
        #2 rst = 1'b1;
        #1;
        check("t6 async valid",    32'(valid),    32'h0);
        check("t6 async data_out", 32'(data_out), 32'h0);
        check("t6 async overrun",  32'(overrun),  32'h0);
        check("t6 async ovr_cnt",  32'(ovr_cnt),  32'h0);
        @(negedge clk);
        rst = 1'b0; exp0.push_back(8'h99);
        wait_neg(LAT - 1);
        check("t6 valid before latency", 32'(valid[0]), 32'h0);
        wait_neg(1);
        check("t6 recapture valid", 32'(valid[0]), 32'h1);
        check("t6 recapture data",  32'(data_out[7:0]), 32'h99);
        stb[0] = 1'b0; ack[0] = 1'b1;
        wait_neg(1);
        ack[0] = 1'b0;
        wait_neg(4);

        check("ch0 scoreboard drained", 32'(exp0.size()), 32'd0);
        check("ch1 scoreboard drained", 32'(exp1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
